// File: rtl/cache_refill_arbiter.sv
// Shares one word-wide bus port between I-cache refills and D-cache refills/stores.
// Refills run as NUM_WORDS read beats assembled MSB-first into a per-port line buffer.
module cache_refill_arbiter #(
  parameter int BLOCK_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  output logic [BLOCK_SIZE*8-1:0] i_rdata,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [31:0]             d_addr,
  input  logic [31:0]             d_wdata,
  input  logic [2:0]              d_size,
  output logic [BLOCK_SIZE*8-1:0] d_rdata,
  output logic                    d_done,
  output logic                    bus_valid,
  output logic [31:0]             bus_addr,
  output logic                    bus_write,
  output logic [31:0]             bus_wdata,
  output logic [2:0]              bus_size,
  input  logic                    bus_ready,
  input  logic [31:0]             bus_rdata
);

  localparam int NUM_WORDS = BLOCK_SIZE / 4;
  localparam int LINE_W    = BLOCK_SIZE * 8;
  localparam int CNT_W     = $clog2(NUM_WORDS) + 1;
  localparam int IDX_W     = $clog2(LINE_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_WORDS - 1);
  localparam logic [31:0]      OFF_MASK  = 32'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic             last_grant;  // 1 = D port
  logic             served;      // 1 = D port
  logic             mask_i, mask_d;
  logic [CNT_W-1:0] cnt;
  logic             elig_i, elig_d, grant_i, grant_d, beat, last;
  logic [CNT_W-1:0] widx;
  logic [IDX_W-1:0] lsb;
  logic [31:0]      beat_data, grant_addr;

  assign elig_i     = i_req & ~mask_i;
  assign elig_d     = d_req & ~mask_d;
  assign grant_i    = (state == IDLE) & elig_i & (~elig_d | last_grant);
  assign grant_d    = (state == IDLE) & elig_d & ~grant_i;
  assign beat       = bus_valid & bus_ready;
  assign last       = beat & (cnt == LAST_BEAT);
  assign widx       = LAST_BEAT - cnt;
  assign lsb        = IDX_W'({widx, 5'd0});
  assign beat_data  = {bus_rdata[7:0], bus_rdata[15:8], bus_rdata[23:16], bus_rdata[31:24]};
  assign grant_addr = grant_i ? i_addr : d_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = I_FILL;
        else if (grant_d) state_nxt = d_we ? D_WRITE : D_FILL;
      end
      I_FILL, D_FILL: if (last) state_nxt = DONE;
      D_WRITE:        if (beat) state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // All outputs are registered; this block produces them from the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_write  <= 1'b0;
      bus_wdata  <= '0;
      bus_size   <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      served     <= 1'b0;
      mask_i     <= 1'b0;
      mask_d     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      // The port just served sits out the following IDLE cycle while it drops req.
      mask_i <= (state == DONE) & ~served;
      mask_d <= (state == DONE) & served;
      case (state)
        IDLE: begin
          if (grant_i | grant_d) begin
            last_grant <= grant_d;
            served     <= grant_d;
            cnt        <= '0;
            bus_valid  <= 1'b1;
            if (grant_d & d_we) begin
              bus_addr  <= d_addr;
              bus_write <= 1'b1;
              bus_wdata <= d_wdata;
              bus_size  <= d_size;
            end else begin
              bus_addr  <= grant_addr & ~OFF_MASK;
              bus_write <= 1'b0;
              bus_wdata <= '0;
              bus_size  <= 3'b010;
            end
            if (grant_i)    i_rdata <= '0;
            else if (!d_we) d_rdata <= '0;
          end
        end
        I_FILL, D_FILL: begin
          if (beat) begin
            cnt <= cnt + CNT_W'(1);
            if (served) d_rdata[lsb +: 32] <= beat_data;
            else        i_rdata[lsb +: 32] <= beat_data;
            if (last) begin
              bus_valid <= 1'b0;
              i_done    <= ~served;
              d_done    <= served;
            end else begin
              bus_addr  <= bus_addr + 32'd4;
            end
          end
        end
        D_WRITE: begin
          if (beat) begin
            cnt       <= cnt + CNT_W'(1);
            bus_valid <= 1'b0;
            d_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench: stimulus predicts whole transactions into a queue, a bus
// responder/monitor pops them as beats and done pulses appear.
module tb_cache_refill_arbiter;
  localparam int BS = 32;
  localparam int NW = BS / 4;
  localparam int LB = BS * 8;
  localparam int CW = LB + 80;
  typedef logic [CW-1:0] cv_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, i_done, d_done;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic [2:0]    d_size;
  logic [LB-1:0] i_rdata, d_rdata;
  logic          bus_valid, bus_write, bus_ready;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata;
  logic [2:0]    bus_size;

  always #5 clk = ~clk;

  cache_refill_arbiter #(.BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata), .d_done(d_done),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_size(bus_size), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit            port;      // 1 = D
    bit            we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [2:0]    size;
    logic [LB-1:0] line;
    int            beats;
    int            start_cyc; // -1: not checked
    int            done_at;   // -1: not checked
    bit            after_prev;
  } txn_t;

  txn_t          q[$];
  txn_t          cur;
  int            checks = 0, failures = 0, cyc = 0;
  bit            active = 0, pending = 0, last_g = 1;
  int            beat_n = 0, done_exp = 0, last_done_cyc = -100, stall_n = 0, ready_mode = 0;
  logic [LB-1:0] ref_i = '0, ref_d = '0;
  logic [31:0]   m_ea;
  bit            m_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input cv_t got, input cv_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Backing memory seen through the bus.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h1122_3344;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [LB-1:0] exp_line(input logic [31:0] a);
    logic [LB-1:0] l;
    logic [31:0]   base, w;
    base = a & ~32'(BS - 1);
    l = '0;
    for (int k = 0; k < NW; k++) begin
      w = rd_word(base + 32'(4 * k));
      l[LB-1-32*k -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return l;
  endfunction

  function automatic txn_t mk(input bit port, input bit we, input logic [31:0] a,
                              input logic [31:0] w, input logic [2:0] s);
    txn_t t;
    t.port = port; t.we = we; t.addr = a; t.wdata = w; t.size = s;
    t.line = we ? '0 : exp_line(a);
    t.beats = we ? 1 : NW;
    t.start_cyc = -1; t.done_at = -1; t.after_prev = 1'b0;
    return t;
  endfunction

  // Bus responder and monitor.
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 0; pending = 0; ref_i = '0; ref_d = '0; bus_ready = 1'b0;
      end else begin
        if (pending && cyc == done_exp) begin
          chk("done_pulse", cv_t'({i_done, d_done, bus_valid}), cv_t'({~cur.port, cur.port, 1'b0}));
          if (cur.done_at >= 0) chk("done_cycle", cv_t'(cyc), cv_t'(cur.done_at));
          if (!cur.we) begin
            if (cur.port) ref_d = cur.line;
            else          ref_i = cur.line;
          end
          chk("i_line", cv_t'(i_rdata), cv_t'(ref_i));
          chk("d_line", cv_t'(d_rdata), cv_t'(ref_d));
          pending = 0;
          last_done_cyc = cyc;
        end else if (i_done || d_done) begin
          chk("spurious_done", cv_t'({i_done, d_done}), cv_t'(2'b00));
        end

        if (bus_valid && !active) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat got addr=%h required=no beat", bus_addr);
          end else begin
            cur = q.pop_front();
            active = 1; beat_n = 0; stall_n = 0;
            if (cur.start_cyc >= 0) chk("start_cycle", cv_t'(cyc), cv_t'(cur.start_cyc));
            if (cur.after_prev) chk("handover_cycle", cv_t'(cyc), cv_t'(last_done_cyc + 2));
          end
        end else if (!bus_valid && active) begin
          checks++; failures++;
          $display("FAIL valid_dropped got beat=%0d required=%0d beats", beat_n, cur.beats);
          active = 0;
        end

        if (active) begin
          m_ea = cur.we ? cur.addr : (cur.addr & ~32'(BS - 1)) + 32'(4 * beat_n);
          chk("beat", cv_t'({bus_addr, bus_write, bus_size, cur.we ? bus_wdata : 32'd0}),
                      cv_t'({m_ea, cur.we, cur.we ? cur.size : 3'b010, cur.we ? cur.wdata : 32'd0}));
        end

        case (ready_mode)
          0:       m_r = 1'b1;
          1:       m_r = ($urandom_range(0, 3) != 0);
          default: m_r = !(active && beat_n == 2 && stall_n < 3);
        endcase
        if (ready_mode == 2 && !m_r) stall_n++;
        bus_ready = m_r;
        bus_rdata = rd_word(bus_addr);

        if (active && bus_ready) begin
          beat_n++;
          if (beat_n == cur.beats) begin
            active = 0; pending = 1; done_exp = cyc + 1;
          end
        end
      end
    end
  end

  // timed_extra < 0: no absolute latency check; otherwise extra stall cycles expected.
  task automatic run_round(input bit ui, input bit ud, input bit dwe,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dw, input logic [2:0] ds,
                           input bit li, input bit ld, input int mode, input int timed_extra);
    txn_t ti, td, first, second;
    bit   idrop, ddrop;
    int   c;
    idrop = 0; ddrop = 0;
    @(negedge clk);
    ready_mode = mode;
    c = cyc;
    ti = mk(1'b0, 1'b0, ia, 32'd0, 3'd0);
    td = mk(1'b1, dwe, da, dw, ds);
    if (ui && ud) begin
      if (last_g) begin first = ti; second = td; end
      else        begin first = td; second = ti; end
      last_g = second.port;
    end else if (ui) begin
      first = ti; second = ti; last_g = 1'b0;
    end else begin
      first = td; second = td; last_g = 1'b1;
    end
    first.start_cyc = c + 1;
    if (timed_extra >= 0) first.done_at = c + 1 + first.beats + timed_extra;
    q.push_back(first);
    if (ui && ud) begin
      second.after_prev = 1'b1;
      q.push_back(second);
    end
    i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dw; d_size = ds;
    i_req = ui; d_req = ud;
    for (int n = 0; n < 400 && (i_req || d_req); n++) begin
      @(negedge clk);
      if (idrop) begin i_req = 1'b0; idrop = 0; end
      else if (i_req && i_done) begin if (li) idrop = 1; else i_req = 1'b0; end
      if (ddrop) begin d_req = 1'b0; ddrop = 0; end
      else if (d_req && d_done) begin if (ld) ddrop = 1; else d_req = 1'b0; end
    end
    checks++;
    if (i_req || d_req) begin
      failures++;
      $display("FAIL round_timeout got req=%b%b required=00", i_req, d_req);
      i_req = 1'b0; d_req = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_fill(input logic [31:0] da);
    txn_t t;
    int   c;
    @(negedge clk);
    ready_mode = 0;
    c = cyc;
    t = mk(1'b1, 1'b0, da, 32'd0, 3'd0);
    t.start_cyc = c + 1;
    q.push_back(t);
    d_addr = da; d_we = 1'b0; d_req = 1'b1;
    while (cyc < c + 5) @(negedge clk);
    chk("pre_reset_beat4", cv_t'({bus_valid, bus_addr}), cv_t'({1'b1, (da & ~32'(BS - 1)) + 32'd16}));
    #2 rst = 1'b0;
    #1 chk("reset_async", cv_t'({bus_valid, d_done, d_rdata}), cv_t'(0));
    q.delete();
    d_req = 1'b0;
    last_g = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ui, ud, dwe, li, ld;
    int sel;
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", cv_t'({bus_valid, bus_addr, bus_write, bus_wdata, bus_size, i_done, d_done}), cv_t'(0));
    chk("reset_lines", cv_t'({i_rdata, d_rdata[31:0]}), cv_t'(0));
    @(negedge clk);
    #2 rst = 1'b1;

    run_round(1, 0, 0, 32'h0000_1014, 32'h0, 32'h0, 3'd0, 0, 0, 0, 0);
    run_round(1, 1, 0, 32'h0000_3008, 32'h0000_4010, 32'h0, 3'd0, 0, 0, 0, 0);
    run_round(1, 1, 0, 32'h0000_6004, 32'h0000_7000, 32'h0, 3'd0, 0, 0, 0, 0);
    run_round(1, 1, 0, 32'h0000_803C, 32'h0000_9020, 32'h0, 3'd0, 0, 0, 0, 0);
    run_round(0, 1, 1, 32'h0, 32'h0000_2003, 32'h0000_00A5, 3'd0, 0, 0, 0, 0);
    run_round(1, 0, 0, 32'h0000_5A3C, 32'h0, 32'h0, 3'd0, 0, 0, 2, 3);
    run_round(1, 0, 0, 32'h0000_0C44, 32'h0, 32'h0, 3'd0, 1, 0, 0, 0);
    run_round(1, 1, 0, 32'h0000_0D00, 32'h0000_0E1C, 32'h0, 3'd0, 1, 1, 0, -1);
    reset_mid_fill(32'h0000_A0A4);
    run_round(1, 0, 0, 32'h0000_1014, 32'h0, 32'h0, 3'd0, 0, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 2));
      ui  = (sel != 1);
      ud  = (sel != 0);
      dwe = 1'($urandom_range(0, 1));
      li  = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      run_round(ui, ud, dwe, $urandom, $urandom, $urandom, 3'($urandom_range(0, 2)), li, ld, 1, -1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", cv_t'({q.size(), active, pending}), cv_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got time=%0t required=finish", $time);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Shares the single word-wide AHB adapter port between the I-cache and D-cache miss/store paths. Arbitrates fairly between the two requesters and sequences a full cache-line refill as BLOCK_SIZE/4 word beats. Assembles each refill into a line buffer and performs D-cache store-through writes as single beats. Sits between the two cache controllers and the AHB adapter in the RV32I core.

## Interface

- BLOCK_SIZE, 32: cache line size in bytes; power of two, 8..64. NUM_WORDS = BLOCK_SIZE/4.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- i_req  in  1  I-cache line refill request; level, held until i_done
- i_addr  in  32  I-cache miss address (any alignment)
- i_rdata  out  BLOCK_SIZE*8  assembled I-cache line
- i_done  out  1  one-cycle pulse: i_rdata valid, transaction finished
- d_req  in  1  D-cache request; level, held until d_done
- d_we  in  1  1 = single-beat store, 0 = line refill
- d_addr  in  32  D-cache address
- d_wdata  in  32  store data
- d_size  in  3  store size code (0 byte, 1 half, 2 word), passed to bus
- d_rdata  out  BLOCK_SIZE*8  assembled D-cache line
- d_done  out  1  one-cycle pulse: refill or store finished
- bus_valid  out  1  beat request to adapter
- bus_addr  out  32  beat address
- bus_write  out  1  beat direction
- bus_wdata  out  32  beat write data
- bus_size  out  3  beat size code
- bus_ready  in  1  beat accepted/completed this cycle
- bus_rdata  in  32  read data, valid when bus_valid && bus_ready && !bus_write

## Operation

- FSM states: IDLE, I_FILL, D_FILL, D_WRITE, DONE.
- IDLE:
  - Samples i_req and d_req, excluding any port masked this cycle (see DONE).
  - Only one eligible request: grant it.
  - Both eligible: grant the port not equal to last_grant.
  - Grant latches the address, d_we, d_wdata and d_size.
  - Grant goes to I_FILL; D_FILL if d_we = 0; D_WRITE if d_we = 1.
  - last_grant updates on each grant. Reset value selects the D port, so the I-cache wins the first tie.
- Refill base address = addr with bits [log2(BLOCK_SIZE)-1:0] cleared.
  - Beat k (0..NUM_WORDS-1) addresses base + 4k.
  - Beat signals: bus_write = 0, bus_size = 3'b010.
- Beat counter (width clog2(NUM_WORDS)+1):
  - Cleared on grant.
  - Increments on each bus_valid && bus_ready.
  - Last beat is the one accepted with counter = NUM_WORDS-1. That beat moves the FSM to DONE.
- Line assembly:
  - Each read beat is byte-reversed: {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}.
  - Beat k is written to line bits [BLOCK_SIZE*8-1-32k : BLOCK_SIZE*8-32-32k], so beat 0 lands in the MSBs.
  - Only the granted port's line register is written.
  - The line register is cleared at grant, not OR-accumulated.
- D_WRITE:
  - One beat: bus_addr = d_addr unmodified, bus_write = 1, bus_wdata = d_wdata, bus_size = d_size.
  - Goes to DONE on bus_ready.
- DONE:
  - Pulses the served port's done for exactly one cycle, then returns to IDLE.
  - In the IDLE cycle immediately after DONE, the served port is masked. The requester must drop req in response to done.
- Line outputs hold their value until that port's next grant.
- bus_ready while bus_valid = 0 is ignored.

## Timing

- All outputs are registered.
- Reset values: bus_valid 0, bus_addr 0, bus_write 0, bus_wdata 0, bus_size 0, i_done 0, d_done 0, i_rdata 0, d_rdata 0, state IDLE, counter 0.
- Refill cycle sequence (req seen in IDLE at cycle 0):
  - bus_valid = 1 with beat 0 from cycle 1.
  - bus_valid stays high continuously until the last beat is accepted.
  - Address advances the cycle after each accepted beat.
- Refill latency with bus_ready tied high: beats in cycles 1..NUM_WORDS, done in cycle NUM_WORDS+1, IDLE in cycle NUM_WORDS+2.
- Store latency with ready high: beat in cycle 1, d_done in cycle 2.
- bus_ready stalls hold bus_addr, bus_write, bus_wdata and bus_size stable.
- A request arriving during a transaction waits. It is granted in the first eligible IDLE cycle.
- Asynchronous reset mid-transaction:
  - Immediately drops bus_valid and the done pulses.
  - Clears both line buffers.
  - Returns the FSM to IDLE.
  - The partial transaction is abandoned, not resumed.

## Test plan

- Reset, then i_req with i_addr = 0x0000_1014, BLOCK_SIZE = 32, ready high.
  - Required: beats at addresses 0x1000..0x101C in cycles 1..8, i_done in cycle 9.
  - Required: beat 0 data 0x11223344 appears as 0x44332211 in i_rdata[255:224].
- i_req and d_req (refill) asserted the same cycle after reset.
  - Required: I fill first, then D fill.
  - Repeat both held: grants alternate I, D, I, D.
- d_req store: d_we = 1, d_addr = 0x2003, d_wdata = 0xA5, d_size = 0, ready high.
  - Required: one beat with bus_write = 1, bus_addr = 0x2003, bus_size = 0; d_done in cycle 2; d_rdata unchanged.
- Refill with bus_ready low for 3 cycles on beat 2.
  - Required: bus_addr held at base + 8 throughout the stall, all 8 words assembled correctly, done delayed by 3 cycles.
- Assert rst low during beat 4 of a D refill.
  - Required: bus_valid 0 and d_rdata 0 immediately.
  - Required: after release, a new i_req completes normally.
- Requester holds req one cycle past done.
  - Required: no duplicate grant to that port in the masked IDLE cycle.
